t07_tft_cmd_queue: RTL and testbench

- Upstream feeder for the team's SPI TFT serializer.
- Accepts 32-bit address/data write commands from the memory handler and buffers them in a FIFO.
- Issues commands one at a time to the serializer using its wi/busy handshake.
- Holds wi high for the whole transfer and inserts a mandatory low gap between transfers, so the memory handler never stalls on SPI timing.

---
 rtl/t07_tft_cmd_queue_if.sv | 37 +++
 rtl/t07_tft_cmd_queue.sv | 140 ++++++++++++++
 tb/tb_t07_tft_cmd_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t07_tft_cmd_queue_if.sv
// Command-queue bus: memory-handler push side and TFT serializer side.
// master = driver of commands and serializer status, slave = the queue.
interface t07_tft_cmd_queue_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en_i;
  logic [31:0]   wr_addr_i;
  logic [31:0]   wr_data_i;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          ovf_o;
  logic          clr_ovf_i;
  logic          tft_busy_i;
  logic          tft_wi_o;
  logic [31:0]   tft_addr_o;
  logic [31:0]   tft_data_o;
  logic          idle_o;
  logic          timeout_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i,
    output clr_ovf_i, tft_busy_i,
    input  full_o, level_o, ovf_o,
    input  tft_wi_o, tft_addr_o, tft_data_o,
    input  idle_o, timeout_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i,
    input  clr_ovf_i, tft_busy_i,
    output full_o, level_o, ovf_o,
    output tft_wi_o, tft_addr_o, tft_data_o,
    output idle_o, timeout_o
  );
endinterface

// File: rtl/t07_tft_cmd_queue.sv
// FIFO of addr/data commands feeding the SPI TFT serializer via wi/busy.
// Optional ISSUE-phase busy timeout: define TFT_TIMEOUT_EN.
module t07_tft_cmd_queue #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  t07_tft_cmd_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_wi;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [GW-1:0] r_gap;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = bus.wr_en_i & ~w_full;
  assign w_pop  = (r_state == S_IDLE) & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.wr_addr_i, bus.wr_data_i};
  end

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.wr_en_i & w_full) r_ovf <= 1'b1;
      else if (bus.clr_ovf_i)   r_ovf <= 1'b0;
    end
  end

`ifdef TFT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_tout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wi    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_gap   <= '0;
`ifdef TFT_TIMEOUT_EN
      r_tcnt  <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
`ifdef TFT_TIMEOUT_EN
      r_tout <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_addr, r_data} <= r_mem[r_rptr];
            r_wi    <= 1'b1;
            r_state <= S_ISSUE;
`ifdef TFT_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.tft_busy_i) r_state <= S_HOLD;
`ifdef TFT_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_tout  <= 1'b1;
            r_wi    <= 1'b0;
            r_gap   <= GW'(GAP_CYCLES - 1);
            r_state <= S_GAP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
`endif
        end
        S_HOLD: begin
          if (!bus.tft_busy_i) begin
            r_wi    <= 1'b0;
            r_gap   <= GW'(GAP_CYCLES - 1);
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= S_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.full_o     = w_full;
  assign bus.level_o    = r_count;
  assign bus.ovf_o      = r_ovf;
  assign bus.tft_wi_o   = r_wi;
  assign bus.tft_addr_o = r_addr;
  assign bus.tft_data_o = r_data;
  assign bus.idle_o     = (r_state == S_IDLE) & (r_count == '0);
`ifdef TFT_TIMEOUT_EN
  assign bus.timeout_o  = r_tout;
`else
  assign bus.timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_t07_tft_cmd_queue.sv
// Random-stimulus bench for t07_tft_cmd_queue with a queue-based reference
// model and a simple serializer model driving tft_busy_i.
module tb_t07_tft_cmd_queue;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  t07_tft_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  t07_tft_cmd_queue #(
    .DEPTH         (DEPTH),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: transfer in flight, waiting-for-busy flag, gap cycles left.
  logic [63:0] mq[$];
  logic [63:0] m_last;
  bit          m_inf, m_held, m_ovf, m_tout;
  int          m_gap, m_tcnt;
  int          tmo_seen;

  // Serializer model: 0 = normal, 1 = stalled busy, 2 = busy tied low.
  int ser_mode, ser_dly, ser_len, ser_cfg_len;
  bit prev_wi;

  function automatic bit m_idle();
    return !m_inf && m_gap == 0 && mq.size() == 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_inf = 0; m_held = 0; m_ovf = 0; m_tout = 0;
    m_gap = 0; m_tcnt = 0;
    ser_dly = 0; ser_len = 0; prev_wi = 0;
  endtask

  task automatic model_edge();
    bit full_pre;
    full_pre = (mq.size() == DEPTH);
    m_tout = 0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_inf) begin
      if (!m_held) begin
        if (bus.tft_busy_i) m_held = 1;
`ifdef TFT_TIMEOUT_EN
        else begin
          m_tcnt++;
          if (m_tcnt == TMO) begin
            m_inf = 0; m_gap = GAP; m_tout = 1;
          end
        end
`endif
      end else if (!bus.tft_busy_i) begin
        m_inf = 0; m_gap = GAP;
      end
    end else if (mq.size() > 0) begin
      m_last = mq.pop_front();
      m_inf = 1; m_held = 0; m_tcnt = 0;
    end
    if (bus.wr_en_i && !full_pre) mq.push_back({bus.wr_addr_i, bus.wr_data_i});
    if (bus.wr_en_i && full_pre) m_ovf = 1;
    else if (bus.clr_ovf_i)      m_ovf = 0;
  endtask

  task automatic check_all();
    chk("wi",      64'(bus.tft_wi_o),   64'(m_inf));
    chk("addr",    64'(bus.tft_addr_o), 64'(m_last[63:32]));
    chk("data",    64'(bus.tft_data_o), 64'(m_last[31:0]));
    chk("level",   64'(bus.level_o),    64'(mq.size()));
    chk("full",    64'(bus.full_o),     64'(mq.size() == DEPTH));
    chk("ovf",     64'(bus.ovf_o),      64'(m_ovf));
    chk("idle",    64'(bus.idle_o),     64'(m_idle()));
    chk("timeout", 64'(bus.timeout_o),  64'(m_tout));
    if (bus.timeout_o) tmo_seen++;
  endtask

  task automatic ser_update();
    if (ser_mode == 1) bus.tft_busy_i = 1'b1;
    else if (ser_mode == 2) bus.tft_busy_i = 1'b0;
    else if (bus.tft_wi_o && !prev_wi) ser_dly = 2;
    else if (ser_dly > 0) begin
      ser_dly--;
      if (ser_dly == 0) begin
        bus.tft_busy_i = 1'b1;
        ser_len = ser_cfg_len;
      end
    end else if (bus.tft_busy_i) begin
      ser_len--;
      if (ser_len <= 0) bus.tft_busy_i = 1'b0;
    end
    prev_wi = bus.tft_wi_o;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    ser_update();
  endtask

  task automatic drain(int budget);
    int k = 0;
    bus.wr_en_i = 1'b0;
    while (!m_idle() && k < budget) begin
      tick();
      k++;
    end
    chk("drain_bound", 64'(k < budget), 64'd1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wi",   64'(bus.tft_wi_o), 64'd0);
    chk("rst_lvl",  64'(bus.level_o),  64'd0);
    chk("rst_idle", 64'(bus.idle_o),   64'd1);
    model_reset();
    bus.wr_en_i    = 1'b0;
    bus.clr_ovf_i  = 1'b0;
    bus.tft_busy_i = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.clr_ovf_i  = 1'b0;
    bus.tft_busy_i = 1'b0;
    ser_mode = 0; ser_cfg_len = 64; tmo_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single command with a 64-cycle serializer busy window
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 32'h0000_0040;
    bus.wr_data_i = 32'hDEAD_BEEF;
    tick();
    bus.wr_en_i = 1'b0;
    chk("t1_lvl", 64'(bus.level_o),  64'd1);
    chk("t1_wi0", 64'(bus.tft_wi_o), 64'd0);
    tick();
    chk("t1_wi",   64'(bus.tft_wi_o),   64'd1);
    chk("t1_addr", 64'(bus.tft_addr_o), 64'h40);
    chk("t1_data", 64'(bus.tft_data_o), 64'hDEAD_BEEF);
    drain(200);
    chk("t1_idle", 64'(bus.idle_o), 64'd1);

    // Three back-to-back pushes; the second coincides with the first pop
    ser_cfg_len = 3;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 32'hA000 + 32'(i);
      bus.wr_data_i = $urandom;
      tick();
      if (i == 1) chk("pp_level", 64'(bus.level_o), 64'd1);
    end
    drain(200);

    // Stalled serializer: fill, overflow, clear
    ser_mode = 1;
    bus.tft_busy_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 32'hB000 + 32'(i);
      bus.wr_data_i = $urandom;
      tick();
    end
    chk("st_full", 64'(bus.full_o),  64'd1);
    chk("st_lvl",  64'(bus.level_o), 64'(DEPTH));
    chk("st_ovf",  64'(bus.ovf_o),   64'd1);
    bus.clr_ovf_i = 1'b1;
    tick();
    chk("st_setwins", 64'(bus.ovf_o), 64'd1);
    bus.wr_en_i = 1'b0;
    tick();
    bus.clr_ovf_i = 1'b0;
    chk("st_clr", 64'(bus.ovf_o), 64'd0);
    ser_mode = 0;
    bus.tft_busy_i = 1'b0;
    drain(400);

    // Random traffic across 3*DEPTH commands to exercise pointer wrap
    sent = 0;
    guard = 0;
    while (sent < 3 * DEPTH && guard < 3000) begin
      ser_cfg_len   = $urandom_range(1, 3);
      bus.wr_en_i   = 1'($urandom_range(0, 1));
      bus.wr_addr_i = $urandom;
      bus.wr_data_i = $urandom;
      bus.clr_ovf_i = ($urandom_range(0, 7) == 0);
      if (bus.wr_en_i) sent++;
      tick();
      guard++;
    end
    chk("rnd_bound", 64'(guard < 3000), 64'd1);
    bus.clr_ovf_i = 1'b0;
    drain(600);

    // Reset while the serializer holds busy
    ser_cfg_len = 20;
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 32'hC0;
    bus.wr_data_i = $urandom;
    tick();
    bus.wr_en_i = 1'b0;
    guard = 0;
    while (!(m_inf && m_held) && guard < 50) begin
      tick();
      guard++;
    end
    chk("hold_bound", 64'(guard < 50), 64'd1);
    tick();
    do_reset();
    ser_cfg_len = 4;
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 32'hD0;
    bus.wr_data_i = $urandom;
    tick();
    bus.wr_en_i = 1'b0;
    tick();
    chk("post_rst_wi",   64'(bus.tft_wi_o),   64'd1);
    chk("post_rst_addr", 64'(bus.tft_addr_o), 64'hD0);
    drain(200);

`ifdef TFT_TIMEOUT_EN
    // Busy never rises: each command times out and is discarded
    ser_mode = 2;
    bus.tft_busy_i = 1'b0;
    tmo_seen = 0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 32'hE0 + 32'(i);
      bus.wr_data_i = $urandom;
      tick();
    end
    drain(200);
    chk("tmo_pulses", 64'(tmo_seen), 64'd2);
    ser_mode = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
